// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps at most one imem request in flight,
// and holds the returned word in a single output slot. Redirects from execute can flush or halt it.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misalign_err_o,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid (imem_req_o / inst_valid_o) and
  // ready (imem_ready_i / inst_ready_i) are both high; a raised valid stays up until taken or flushed.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_inst_q, slot_inst_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic        err_q, err_d;

  logic slot_free;
  logic accept;
  logic consume;
  logic redir_any;
  logic redir_ok;
  logic redir_bad;
  logic fill;

  always_comb begin
    slot_free = !slot_valid_q || inst_ready_i;
    imem_req_o = (state_q == ST_REQ) && slot_free;
    accept = imem_req_o && imem_ready_i;
    consume = slot_valid_q && inst_ready_i;
    redir_any = redirect_valid_i && (state_q != ST_HALT);
    redir_bad = redir_any && (redirect_pc_i[1:0] != 2'b00);
    redir_ok = redir_any && (redirect_pc_i[1:0] == 2'b00);
    // A response is delivered only if it belongs to the current flow and no redirect arrives with it.
    fill = (state_q == ST_WAIT) && imem_rvalid_i && !kill_q && !redir_any;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    slot_valid_d = slot_valid_q;
    slot_inst_d  = slot_inst_q;
    slot_pc_d    = slot_pc_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (consume) slot_valid_d = 1'b0;
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (consume) slot_valid_d = 1'b0;
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          if (fill) begin
            slot_valid_d = 1'b1;
            slot_inst_d  = imem_rdata_i;
            slot_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      default: begin
        slot_valid_d = 1'b0;
      end
    endcase

    // Redirects override everything above, including a same-cycle consume or response.
    if (redir_bad) begin
      state_d      = ST_HALT;
      err_d        = 1'b1;
      slot_valid_d = 1'b0;
      kill_d       = 1'b0;
      pc_d         = pc_q;
    end else if (redir_ok) begin
      pc_d         = redirect_pc_i;
      slot_valid_d = 1'b0;
      if (accept) kill_d = 1'b1;
      if ((state_q == ST_WAIT) && !imem_rvalid_i) kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_inst_q  <= NOP;
      slot_pc_q    <= RESET_PC;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      slot_valid_q <= slot_valid_d;
      slot_inst_q  <= slot_inst_d;
      slot_pc_q    <= slot_pc_d;
      err_q        <= err_d;
    end
  end

  assign imem_addr_o    = pc_q;
  assign inst_valid_o   = slot_valid_q;
  assign inst_o         = slot_inst_q;
  assign inst_pc_o      = slot_pc_q;
  assign misalign_err_o = err_q;
  assign dbg_state_o    = state_q;

endmodule
